strip_allocator: RTL and testbench

Placement stage directly downstream of the `rom_strip_id` candidate ROM. It accepts one rectangle (height, width) per transaction and maps the height to a ROM address, which it drives with an enable. It then walks the three returned strip-id candidates in priority order and places the rectangle in the first valid strip with enough remaining width. It keeps a per-strip fill pointer and returns the chosen strip and x offset, or a reject, on a valid/ready output.

---
 rtl/strip_pkg.sv | 36 +++
 rtl/strip_fill_bank.sv | 56 +++++
 rtl/strip_allocator.sv | 211 +++++++++++++++++++++
 tb/tb_strip_allocator.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_pkg.sv
// ============================================================================
// Module   : strip_pkg
// Brief    : Shared constants, FSM state encoding and the height-to-ROM-address
//            map for the strip allocator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package strip_pkg;

    localparam int         NUM_STRIPS_DEF   = 13;
    localparam logic [3:0] STRIP_ID_INVALID = 4'hD;
    localparam logic [4:0] H_MIN            = 5'd4;
    localparam logic [4:0] H_MAX            = 5'd16;
    localparam logic [4:0] H_CLAMP          = 5'd13;
    localparam logic [3:0] ROM_ADDR_MAX     = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Heights 4..12 map linearly onto addresses 0..8; all taller heights
    // share the last ROM row. Caller guarantees h is already in range.
    function automatic logic [3:0] map_height(input logic [4:0] h);
        if (h >= H_CLAMP) begin
            return ROM_ADDR_MAX;
        end
        return 4'(h - H_MIN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/strip_fill_bank.sv
// ============================================================================
// Module   : strip_fill_bank
// Brief    : Per-strip fill pointers. One combinational read port, one
//            accumulate-style write port, synchronous clear, async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module strip_fill_bank #(
    parameter int NUM_STRIPS = 13,
    parameter int W_BITS     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [3:0]        rd_id,
    output logic [W_BITS-1:0] rd_used,
    input  logic [3:0]        wr_id,
    input  logic [W_BITS-1:0] wr_add,
    input  logic              we
);

    logic [W_BITS-1:0] r_used [NUM_STRIPS];

    // Fill pointers: zeroed by reset or clear, otherwise advanced by wr_add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
                r_used[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
                r_used[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
                if (we && (wr_id == 4'(i))) begin
                    r_used[i] <= r_used[i] + wr_add;
                end
            end
        end
    end

    // Read port; out-of-range ids read as zero.
    always_comb begin
        rd_used = '0;
        for (int i = 0; i < NUM_STRIPS; i++) begin
            if (rd_id == 4'(i)) begin
                rd_used = r_used[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/strip_allocator.sv
// ============================================================================
// Module   : strip_allocator
// Brief    : Maps a rectangle height to a candidate-ROM address, walks the
//            three returned strip ids in priority order and places the
//            rectangle in the first valid strip with room left.
// Config   : STRIP_ALLOC_STATS_EN adds saturating placed/rejected counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module strip_allocator
    import strip_pkg::*;
#(
    parameter int STRIP_W    = 64,
    parameter int W_BITS     = 7,
    parameter int NUM_STRIPS = NUM_STRIPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_height,
    input  logic [W_BITS-1:0] in_width,
    output logic              rom_en,
    output logic [3:0]        rom_addr,
    input  logic [3:0]        rom_id1,
    input  logic [3:0]        rom_id2,
    input  logic [3:0]        rom_id3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ok,
    output logic [3:0]        out_strip,
    output logic [W_BITS-1:0] out_x
`ifdef STRIP_ALLOC_STATS_EN
    ,
    output logic [15:0]       stat_placed,
    output logic [15:0]       stat_rejected
`endif
);

    state_t            r_state, w_state_nx;
    logic [1:0]        r_idx, w_idx_nx;
    logic [W_BITS-1:0] r_width, w_width_nx;
    logic              r_rom_en, w_rom_en_nx;
    logic [3:0]        r_rom_addr, w_rom_addr_nx;
    logic              r_out_ok, w_out_ok_nx;
    logic [3:0]        r_out_strip, w_out_strip_nx;
    logic [W_BITS-1:0] r_out_x, w_out_x_nx;

    logic [3:0]        w_cand;
    logic              w_cand_valid;
    logic [W_BITS-1:0] w_used;
    logic [W_BITS:0]   w_sum;
    logic              w_fits;
    logic              w_commit;
    logic              w_clear;
    logic              w_bad_req;

    assign in_ready  = (r_state == ST_IDLE) && !clear;
    assign w_clear   = clear && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign rom_en    = r_rom_en;
    assign rom_addr  = r_rom_addr;
    assign out_ok    = r_out_ok;
    assign out_strip = r_out_strip;
    assign out_x     = r_out_x;

    assign w_bad_req = (in_height < H_MIN) || (in_height > H_MAX) || (in_width == '0);

    // Priority select of the candidate currently under evaluation.
    always_comb begin
        w_cand = rom_id3;
        case (r_idx)
            2'd0:    w_cand = rom_id1;
            2'd1:    w_cand = rom_id2;
            default: w_cand = rom_id3;
        endcase
    end

    // Sum is one bit wider so an oversized width cannot wrap into a fit.
    assign w_cand_valid = (int'(w_cand) < NUM_STRIPS);
    assign w_sum        = {1'b0, w_used} + {1'b0, r_width};
    assign w_fits       = (w_sum <= (W_BITS+1)'(STRIP_W));
    assign w_commit     = (r_state == ST_CHECK) && w_cand_valid && w_fits;

    strip_fill_bank #(
        .NUM_STRIPS (NUM_STRIPS),
        .W_BITS     (W_BITS)
    ) u_fill_bank (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .rd_id   (w_cand),
        .rd_used (w_used),
        .wr_id   (w_cand),
        .wr_add  (r_width),
        .we      (w_commit)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_width     <= '0;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= 4'd0;
            r_out_ok    <= 1'b0;
            r_out_strip <= 4'd0;
            r_out_x     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_width     <= w_width_nx;
            r_rom_en    <= w_rom_en_nx;
            r_rom_addr  <= w_rom_addr_nx;
            r_out_ok    <= w_out_ok_nx;
            r_out_strip <= w_out_strip_nx;
            r_out_x     <= w_out_x_nx;
        end
    end

    // Next-state and next-register values; the result fields are zeroed on
    // accept so a reject never needs to touch them again.
    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_width_nx     = r_width;
        w_rom_en_nx    = 1'b0;
        w_rom_addr_nx  = r_rom_addr;
        w_out_ok_nx    = r_out_ok;
        w_out_strip_nx = r_out_strip;
        w_out_x_nx     = r_out_x;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && !clear) begin
                    w_width_nx     = in_width;
                    w_out_ok_nx    = 1'b0;
                    w_out_strip_nx = 4'd0;
                    w_out_x_nx     = '0;
                    if (w_bad_req) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_state_nx    = ST_LOOKUP;
                        w_rom_en_nx   = 1'b1;
                        w_rom_addr_nx = map_height(in_height);
                    end
                end
            end
            ST_LOOKUP: begin
                w_idx_nx   = 2'd0;
                w_state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_cand_valid && w_fits) begin
                    w_out_ok_nx    = 1'b1;
                    w_out_strip_nx = w_cand;
                    w_out_x_nx     = w_used;
                    w_state_nx     = ST_DONE;
                end else if (r_idx < 2'd2) begin
                    w_idx_nx = r_idx + 2'd1;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

`ifdef STRIP_ALLOC_STATS_EN
    logic        w_done_hs;
    logic [15:0] r_stat_placed;
    logic [15:0] r_stat_rejected;

    assign w_done_hs     = (r_state == ST_DONE) && out_ready;
    assign stat_placed   = r_stat_placed;
    assign stat_rejected = r_stat_rejected;

    // Saturating outcome counters, bumped once per delivered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_placed   <= 16'd0;
            r_stat_rejected <= 16'd0;
        end else if (w_clear) begin
            r_stat_placed   <= 16'd0;
            r_stat_rejected <= 16'd0;
        end else if (w_done_hs) begin
            if (r_out_ok) begin
                if (r_stat_placed != 16'hFFFF) begin
                    r_stat_placed <= r_stat_placed + 16'd1;
                end
            end else begin
                if (r_stat_rejected != 16'hFFFF) begin
                    r_stat_rejected <= r_stat_rejected + 16'd1;
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_strip_allocator.sv
// ============================================================================
// Module   : tb_strip_allocator
// Brief    : Self-checking bench for strip_allocator with a behavioural
//            candidate ROM, a vector table and a result scoreboard queue.
// Config   : STRIP_ALLOC_STATS_EN enables the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_strip_allocator;

    localparam int W_BITS = 7;
    localparam int NVEC   = 18;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              clear     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic [4:0]        in_height = 5'd0;
    logic [W_BITS-1:0] in_width  = '0;
    logic [3:0]        rom_id1   = 4'd0;
    logic [3:0]        rom_id2   = 4'd0;
    logic [3:0]        rom_id3   = 4'd0;
    logic              in_ready;
    logic              rom_en;
    logic [3:0]        rom_addr;
    logic              out_valid;
    logic              out_ok;
    logic [3:0]        out_strip;
    logic [W_BITS-1:0] out_x;
`ifdef STRIP_ALLOC_STATS_EN
    logic [15:0]       stat_placed;
    logic [15:0]       stat_rejected;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic              ok;
        logic [3:0]        strip;
        logic [W_BITS-1:0] x;
    } res_t;

    // addr == 4'hF marks a request that must never touch the ROM.
    typedef struct {
        logic [4:0]        h;
        logic [W_BITS-1:0] w;
        logic [3:0]        addr;
        logic              ok;
        logic [3:0]        strip;
        logic [W_BITS-1:0] x;
        int                lat;
    } vec_t;

    res_t sb_q[$];
    vec_t vecs[NVEC];

    strip_allocator dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_height (in_height),
        .in_width  (in_width),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_id1   (rom_id1),
        .rom_id2   (rom_id2),
        .rom_id3   (rom_id3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ok    (out_ok),
        .out_strip (out_strip),
        .out_x     (out_x)
`ifdef STRIP_ALLOC_STATS_EN
        ,
        .stat_placed   (stat_placed),
        .stat_rejected (stat_rejected)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_data(input logic [3:0] a);
        case (a)
            4'd0:    rom_data = {4'd9, 4'd7, 4'hD};
            4'd4:    rom_data = {4'd0, 4'd1, 4'd2};
            4'd9:    rom_data = {4'd3, 4'd4, 4'd5};
            default: rom_data = {4'd10, 4'd11, 4'd12};
        endcase
    endfunction

    // Registered candidate ROM, loaded only while enabled.
    always @(posedge clk) begin
        if (rom_en) begin
            {rom_id1, rom_id2, rom_id3} <= rom_data(rom_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issue one request (called at a falling edge, out_ready high), then
    // check latency, ROM activity and the popped scoreboard result.
    task automatic run_req(input vec_t v);
        int         cyc;
        int         guard;
        bit         seen_en;
        logic [3:0] addr1;
        res_t       e;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_req", in_ready, 1);
        in_height = v.h;
        in_width  = v.w;
        in_valid  = 1'b1;
        e.ok = v.ok; e.strip = v.strip; e.x = v.x;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        cyc      = 1;
        seen_en  = 1'b0;
        addr1    = rom_addr;
        while (!out_valid && cyc < 20) begin
            if (rom_en) seen_en = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (rom_en) seen_en = 1'b1;
        chk("latency", cyc, v.lat);
        chk("rom_en_seen", seen_en, (v.addr != 4'hF));
        if (v.addr != 4'hF) chk("rom_addr", addr1, v.addr);
        if (out_valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_ok", out_ok, e.ok);
            chk("out_strip", out_strip, e.strip);
            chk("out_x", out_x, e.x);
        end else begin
            chk("out_valid_timeout", out_valid, 1);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        res_t e;
        vec_t v;

        vecs[0]  = '{5'd8,  7'd10, 4'd4, 1'b1, 4'd0,  7'd0,  3};
        vecs[1]  = '{5'd8,  7'd10, 4'd4, 1'b1, 4'd0,  7'd10, 3};
        vecs[2]  = '{5'd8,  7'd10, 4'd4, 1'b1, 4'd0,  7'd20, 3};
        vecs[3]  = '{5'd8,  7'd10, 4'd4, 1'b1, 4'd0,  7'd30, 3};
        vecs[4]  = '{5'd8,  7'd10, 4'd4, 1'b1, 4'd0,  7'd40, 3};
        vecs[5]  = '{5'd8,  7'd10, 4'd4, 1'b1, 4'd0,  7'd50, 3};
        vecs[6]  = '{5'd8,  7'd10, 4'd4, 1'b1, 4'd1,  7'd0,  4};
        vecs[7]  = '{5'd4,  7'd64, 4'd0, 1'b1, 4'd9,  7'd0,  3};
        vecs[8]  = '{5'd4,  7'd64, 4'd0, 1'b1, 4'd7,  7'd0,  4};
        vecs[9]  = '{5'd4,  7'd64, 4'd0, 1'b0, 4'd0,  7'd0,  5};
        vecs[10] = '{5'd13, 7'd5,  4'd9, 1'b1, 4'd3,  7'd0,  3};
        vecs[11] = '{5'd16, 7'd5,  4'd9, 1'b1, 4'd3,  7'd5,  3};
        vecs[12] = '{5'd3,  7'd5,  4'hF, 1'b0, 4'd0,  7'd0,  1};
        vecs[13] = '{5'd17, 7'd5,  4'hF, 1'b0, 4'd0,  7'd0,  1};
        vecs[14] = '{5'd8,  7'd0,  4'hF, 1'b0, 4'd0,  7'd0,  1};
        vecs[15] = '{5'd12, 7'd64, 4'd8, 1'b1, 4'd10, 7'd0,  3};
        vecs[16] = '{5'd8,  7'd4,  4'd4, 1'b1, 4'd0,  7'd60, 3};
        vecs[17] = '{5'd8,  7'd1,  4'd4, 1'b1, 4'd1,  7'd10, 4};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ok", out_ok, 0);
        chk("rst_out_strip", out_strip, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_req(vecs[i]);
        end

        // Backpressure: strip 0 is full, strip 1 holds 11 units.
        out_ready = 1'b0;
        in_height = 5'd8;
        in_width  = 7'd10;
        in_valid  = 1'b1;
        e.ok = 1'b1; e.strip = 4'd1; e.x = 7'd11;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", cyc, 4);
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_ok", out_ok, e.ok);
            chk("bp_strip", out_strip, e.strip);
            chk("bp_x", out_x, e.x);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);

        // Clear wins over a simultaneous request.
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_height = 5'd8;
        in_width  = 7'd10;
        #1;
        chk("clear_in_ready", in_ready, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clear_no_accept_valid", out_valid, 0);
        chk("clear_no_accept_rom_en", rom_en, 0);
        chk("clear_in_ready_back", in_ready, 1);
`ifdef STRIP_ALLOC_STATS_EN
        chk("clear_stat_placed", stat_placed, 0);
        chk("clear_stat_rejected", stat_rejected, 0);
`endif
        v = '{5'd8, 7'd10, 4'd4, 1'b1, 4'd0, 7'd0, 3};
        run_req(v);
`ifdef STRIP_ALLOC_STATS_EN
        chk("stat_placed_one", stat_placed, 1);
`endif

        // Reset while evaluating the first candidate of an h=4 request.
        @(negedge clk);
        in_height = 5'd4;
        in_width  = 7'd64;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 0);
        rst = 1'b1;
        #1;
        chk("rst_check_out_valid", out_valid, 0);
        chk("rst_check_in_ready", in_ready, 1);
        chk("rst_check_rom_en", rom_en, 0);
        @(negedge clk);
        rst = 1'b0;
`ifdef STRIP_ALLOC_STATS_EN
        chk("rst_stat_placed", stat_placed, 0);
        chk("rst_stat_rejected", stat_rejected, 0);
`endif
        v = '{5'd8, 7'd60, 4'd4, 1'b1, 4'd0, 7'd0, 3};
        run_req(v);
        v = '{5'd4, 7'd64, 4'd0, 1'b1, 4'd9, 7'd0, 3};
        run_req(v);

        // Reset while a result is being held in DONE.
        out_ready = 1'b0;
        in_height = 5'd8;
        in_width  = 7'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_hold_valid", out_valid, 1);
        chk("done_hold_ok", out_ok, 1);
        chk("done_hold_x", out_x, 60);
        rst = 1'b1;
        #1;
        chk("rst_done_out_valid", out_valid, 0);
        chk("rst_done_out_ok", out_ok, 0);
        chk("rst_done_out_x", out_x, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("final_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
